// File: rtl/cal_mac_requant_if.sv
// rtl/cal_mac_requant_if.sv - beat, config and result signals of cal_mac_requant
interface cal_mac_requant_if #(
  parameter int DATA_W = 4,
  parameter int MULT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] w_in;
  logic [MULT_W-1:0] multiplier;
  logic [4:0]        shift;
  logic [3:0]        zero_point;
  logic              out_valid;
  logic [3:0]        data_out;
  logic              acc_sat;

  modport master (
    output in_valid, in_last, a_in, w_in, multiplier, shift, zero_point,
    input  in_ready, out_valid, data_out, acc_sat
  );

  modport slave (
    input  in_valid, in_last, a_in, w_in, multiplier, shift, zero_point,
    output in_ready, out_valid, data_out, acc_sat
  );
endinterface

// File: rtl/cal_mac_requant.sv
// rtl/cal_mac_requant.sv - MAC over zero-point-corrected pairs, fixed-point rescale, +z3, int4 saturate
module cal_mac_requant #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16,
  parameter int MULT_W = 16
) (
  input logic clk,
  input logic rst,
  cal_mac_requant_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SC_W   = ACC_W + MULT_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SC_W+1:0]  V_MAX   = {{(SC_W-2){1'b0}}, 4'b0111};
  localparam logic signed [SC_W+1:0]  V_MIN   = {{(SC_W-2){1'b1}}, 4'b1000};

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_SCALE, S_ROUND} state_t;
  state_t state, state_nx;

  logic signed [PROD_W-1:0] prod;
  logic                     prod_v;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_sat_q;
  logic signed [SC_W-1:0]   scaled;
  logic [MULT_W-1:0]        mult_q;
  logic [4:0]               shift_q;
  logic [3:0]               zp_q;
  logic                     out_valid_q;
  logic [3:0]               data_q;

  logic                     ready;
  logic                     accept;
  logic signed [PROD_W-1:0] a_ext, w_ext;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  sum_sat;
  logic                     sum_ovf;
  logic signed [SC_W-1:0]   acc_ext, mult_ext;
  logic signed [SC_W:0]     rnd_bias, rnd_sum, rnd_val;
  logic signed [SC_W+1:0]   v_wide;
  logic [3:0]               v_clamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_ACC: begin
        ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = S_SCALE;
      S_SCALE: state_nx = S_ROUND;
      S_ROUND: state_nx = S_ACC;
      default: state_nx = S_ACC;
    endcase
  end

  always_comb begin
    accept   = bus.in_valid && ready;
    a_ext    = {{DATA_W{bus.a_in[DATA_W-1]}}, bus.a_in};
    w_ext    = {{DATA_W{bus.w_in[DATA_W-1]}}, bus.w_in};
    // One guard bit: overflow shows as disagreement between the top two bits.
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum_sat  = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    acc_ext  = {{(MULT_W+1){acc[ACC_W-1]}}, acc};
    mult_ext = {{(ACC_W+1){1'b0}}, mult_q};
    // Bias is 2^(shift-1), collapsing to zero when shift is zero.
    rnd_bias = ({{SC_W{1'b0}}, 1'b1} << shift_q) >> 1;
    rnd_sum  = {scaled[SC_W-1], scaled} + rnd_bias;
    rnd_val  = rnd_sum >>> shift_q;
    v_wide   = {rnd_val[SC_W], rnd_val} + {{(SC_W-2){zp_q[3]}}, zp_q};
    if (v_wide > V_MAX)      v_clamp = 4'b0111;
    else if (v_wide < V_MIN) v_clamp = 4'b1000;
    else                     v_clamp = v_wide[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod        <= '0;
      prod_v      <= 1'b0;
      acc         <= '0;
      acc_sat_q   <= 1'b0;
      scaled      <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      zp_q        <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      prod_v      <= accept;
      if (accept) prod <= a_ext * w_ext;
      if (accept && bus.in_last) begin
        mult_q  <= bus.multiplier;
        shift_q <= bus.shift;
        zp_q    <= bus.zero_point;
      end
      if (state == S_SCALE) scaled <= acc_ext * mult_ext;
      if (state == S_ROUND) begin
        acc         <= '0;
        prod_v      <= 1'b0;
        acc_sat_q   <= 1'b0;
        data_q      <= v_clamp;
        out_valid_q <= 1'b1;
      end else if (prod_v) begin
        acc <= sum_sat;
        if (sum_ovf) acc_sat_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.acc_sat   = acc_sat_q;
endmodule

// File: tb/tb_cal_mac_requant.sv
// tb/tb_cal_mac_requant.sv - randomized and directed bench for cal_mac_requant against a behavioural model
module tb_cal_mac_requant;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cal_mac_requant_if #(.DATA_W(4), .MULT_W(16)) bus ();

  cal_mac_requant #(.DATA_W(4), .ACC_W(16), .MULT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_sum = 0;
  int m_cnt = 0;
  int m_res = 0;
  int m_do = 0;
  bit m_ready = 1'b1;
  bit m_ov = 1'b0;
  bit m_sat = 1'b0;
  bit sat_prev = 1'b0;
  bit take = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int requant(input int sum, input int mult, input int sh, input int zp);
    longint sc, r;
    sc = longint'(sum) * longint'(mult);
    r = (sh > 0) ? ((sc + (longint'(1) << (sh - 1))) >>> sh) : sc;
    r = r + longint'(zp);
    if (r > 7) r = 7;
    if (r < -8) r = -8;
    return int'(r);
  endfunction

  // Element-level model: products summed with clamping, result due four edges after the last beat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_ready = 1'b1; m_ov = 1'b0;
      m_do = 0; m_sat = 1'b0; sat_prev = 1'b0;
    end else begin
      take = bus.in_valid && m_ready;
      m_ov = (m_cnt == 1);
      if (m_cnt == 1) begin
        m_do = m_res;
        m_sat = 1'b0;
      end else if (sat_prev) begin
        m_sat = 1'b1;
      end
      if (m_cnt > 0) m_cnt--;
      sat_prev = 1'b0;
      if (take) begin
        m_sum += int'($signed(bus.a_in)) * int'($signed(bus.w_in));
        if (m_sum > 32767) begin m_sum = 32767; sat_prev = 1'b1; end
        else if (m_sum < -32768) begin m_sum = -32768; sat_prev = 1'b1; end
        if (bus.in_last) begin
          m_res = requant(m_sum, int'(bus.multiplier), int'(bus.shift), int'($signed(bus.zero_point)));
          m_sum = 0;
          m_cnt = 3;
        end
      end
      m_ready = (m_cnt == 0);
    end
  end

  always @(negedge clk) begin
    check("in_ready", bus.in_ready, m_ready);
    check("out_valid", bus.out_valid, m_ov);
    check("data_out", $signed(bus.data_out), m_do);
    check("acc_sat", bus.acc_sat, m_sat);
  end

  task automatic set_cfg(input int mult, input int sh, input int zp);
    bus.multiplier = 16'(mult);
    bus.shift = 5'(sh);
    bus.zero_point = 4'(zp);
  endtask

  task automatic beat(input int a, input int w, input bit last);
    int n = 0;
    while (!m_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 20 cycles");
    end
    bus.a_in = 4'(a); bus.w_in = 4'(w); bus.in_last = last; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_out(input int exp, input int lat_exp, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 12);
    if (!bus.out_valid) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got no out_valid expected pulse within 12 cycles", name);
    end else begin
      check({name, "_data"}, $signed(bus.data_out), exp);
      check({name, "_model"}, m_do, exp);
      if (lat_exp > 0) check({name, "_latency"}, n, lat_exp);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.a_in = '0; bus.w_in = '0;
    set_cfg(0, 0, 0);
    check("pin_t2", requant(196, 1, 5, 1), 7);
    check("pin_round_neg", requant(-5, 1, 1, 0), -2);
    check("pin_round_pos", requant(5, 1, 1, 0), 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", $signed(bus.data_out), 0);
    check("rst_acc_sat", bus.acc_sat, 0);
    @(posedge clk); #1 rst = 1'b0;

    set_cfg(1, 0, 0);
    beat(3, 2, 1'b1);
    wait_out(6, 4, "t1");

    set_cfg(1, 5, 1);
    repeat (3) beat(7, 7, 1'b0);
    beat(7, 7, 1'b1);
    wait_out(7, 4, "t2");

    set_cfg(1, 0, 0);
    repeat (3) beat(7, 7, 1'b0);
    beat(7, 7, 1'b1);
    wait_out(7, 4, "t3_pos");
    beat(-8, 7, 1'b1);
    wait_out(-8, 4, "t3_neg");

    set_cfg(1, 1, 0);
    beat(-5, 1, 1'b1);
    wait_out(-2, 4, "t4_neg");
    beat(5, 1, 1'b1);
    wait_out(3, 4, "t4_pos");

    set_cfg(1, 0, 0);
    bus.a_in = 4'(3); bus.w_in = 4'(2); bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a_in = 4'(1); bus.w_in = 4'(1);
    wait_out(6, 4, "t5_first");
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_out(1, 4, "t5_second");

    beat(7, 7, 1'b0);
    beat(7, 7, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_data_out", $signed(bus.data_out), 0);
    check("t6_acc_sat", bus.acc_sat, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    set_cfg(1, 0, 0);
    beat(1, 1, 1'b1);
    wait_out(1, 4, "t6");
    check("t6_sat_after", bus.acc_sat, 0);

    set_cfg(1, 15, 0);
    repeat (519) beat(-8, -8, 1'b0);
    @(negedge clk);
    check("t7_sat_sticky", bus.acc_sat, 1);
    beat(-8, -8, 1'b1);
    wait_out(1, 4, "t7");

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_last = ($urandom_range(0, 5) == 0);
      bus.a_in = 4'($urandom);
      bus.w_in = 4'($urandom);
      if ($urandom_range(0, 1) == 1) bus.multiplier = 16'($urandom_range(0, 300));
      else bus.multiplier = 16'($urandom);
      if ($urandom_range(0, 1) == 1) bus.shift = 5'($urandom_range(4, 14));
      else bus.shift = 5'($urandom_range(0, 31));
      bus.zero_point = 4'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected end of run before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule
